frame_loader: RTL and testbench
===============================

Name: frame_loader

Overview:
- Packet parser that fills the display's dual-port frame memory (port A) from a byte stream, e.g. a UART receiver.
- Sits directly upstream of rgb_display and drives its addr_a / data_in_a / wr_en inputs.
- Supports two commands: block pixel write and rectangular-free linear fill.
- Reports completion and error pulses to the system controller.

Parameters:
- MEM_WORDS, 2304, number of valid frame words (96 columns x 24 row-pairs); legal addresses are 0..MEM_WORDS-1.
- TIMEOUT, 2500000, maximum idle cycles between bytes inside a packet (100 ms at 25 MHz).
- SYNC, 8'hA5, packet start byte.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  synchronous, active-high reset.
- i_rx_data  in  8  incoming byte.
- i_rx_valid  in  1  i_rx_data is valid this cycle.
- o_rx_ready  out  1  loader accepts a byte this cycle.
- o_addr  out  12  frame memory word address (drives addr_a).
- o_data  out  24  frame word: [23:12] top-half pixel {R,G,B} 4b each, [11:0] bottom-half pixel (drives data_in_a).
- o_wr_en  out  1  memory write strobe (drives wr_en).
- o_busy  out  1  a packet is in progress (any state except IDLE).
- o_done  out  1  one-cycle pulse: packet completed with a good checksum.
- o_err  out  1  one-cycle pulse: packet aborted or checksum bad.
- o_err_code  out  2  valid with o_err: 0 timeout, 1 bad command, 2 bad range, 3 checksum mismatch.

Behaviour:
- Reset, and the cycle after i_rst: all outputs 0 except o_rx_ready=1; state IDLE; counters and checksum cleared. Reset during FILL stops writes on the next edge.
- Byte accepted when i_rx_valid && o_rx_ready. o_rx_ready=0 only in FILL and while i_rst is high.
- Packet format: SYNC, CMD, ADDR_H (bits [3:0] used), ADDR_L, LEN_H, LEN_L, payload, CSUM.
- LEN is the word count; LEN[15:12] must be 0.
- CSUM = XOR of CMD through the last payload byte.
- States: IDLE -> CMD -> ADH -> ADL -> LNH -> LNL -> (P0 -> P1 -> P2)* -> CSUM -> [FILL] -> IDLE.
- IDLE discards every byte other than SYNC.
- CMD: 8'h01 = write, payload is LEN x 3 bytes. 8'h02 = fill, payload is 3 bytes, one colour word. Any other value: o_err code 1, return to IDLE.
- Range check in LNL: fail if LEN==0 or ADDR+LEN > MEM_WORDS (13-bit compare). On fail: o_err code 2, return to IDLE, no writes. Remaining bytes are then hunted through for SYNC; a payload byte equal to SYNC may falsely start a packet, and this is accepted.
- Word assembly: P0 -> data[23:16], P1 -> data[15:8], P2 -> data[7:0].
- Write command: o_wr_en=1 for exactly one cycle, the cycle after P2 is accepted, with o_addr = ADDR+n for the n-th word.
  - After the LEN-th word, go to CSUM, otherwise back to P0.
  - Writes are not retracted on a checksum failure.
- CSUM byte: on match, write command pulses o_done and returns to IDLE; fill command enters FILL. On mismatch: o_err code 3, IDLE, and no fill.
- FILL: one write per cycle, o_addr = ADDR..ADDR+LEN-1, o_data = colour word, o_wr_en held high for LEN consecutive cycles. o_done pulses the cycle after the last write; state is IDLE on that same cycle.
- Timeout: a cycle counter runs in states CMD..CSUM, clears on every accepted byte, and holds 0 in IDLE and FILL. When it reaches TIMEOUT-1: o_err code 0, return to IDLE.
- o_done and o_err are never high together. o_addr and o_data hold their last values when o_wr_en=0.

Test Plan:
- Write packet A5 01 00 10 00 02, then 6 payload bytes, then correct CSUM -> two single-cycle writes: addr 0x010 and 0x011 with data {B0,B1,B2} and {B3,B4,B5}; o_done pulses once; o_err stays 0.
- Fill packet A5 02 08 FC 00 04, colour 12 34 56, correct CSUM -> o_rx_ready low for 4 cycles; writes to addr 0x8FC..0x8FF with data 0x123456; o_done the cycle after addr 0x8FF.
- Range failure: ADDR=0x8FF, LEN=2 (sum 2305 > 2304) -> o_err code 2 right after LEN_L; no o_wr_en. Same failure for LEN=0.
- Checksum mismatch on a 1-word write -> word written, then o_err code 3 and no o_done. On a fill -> zero writes and o_err code 3.
- Bad CMD 8'h07 -> o_err code 1. A 9-cycle gap after ADDR_L with TIMEOUT=8 -> o_err code 0 and return to IDLE; a following valid packet is then processed normally.
- Assert i_rst mid-FILL, two writes into a LEN=10 fill -> o_wr_en=0 the cycle after reset; all outputs at reset values; the next packet works.

Source files
------------

// File: rtl/frame_loader.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module      : frame_loader
// Description : Byte-stream packet parser that fills the display frame memory
//               (port A of the dual-port RAM in front of rgb_display).
//               Packet: SYNC, CMD, ADDR_H, ADDR_L, LEN_H, LEN_L, payload, CSUM
//                 CMD 8'h01 : block write, LEN words of 3 payload bytes each
//                 CMD 8'h02 : linear fill, one 3-byte colour word, LEN copies
//               CSUM is the XOR of CMD through the last payload byte.
// Ports       :
//   i_clk        system clock
//   i_rst        synchronous active-high reset
//   i_rx_data    incoming byte
//   i_rx_valid   i_rx_data valid this cycle
//   o_rx_ready   loader accepts a byte this cycle (low in FILL and in reset)
//   o_addr       frame memory word address         (to addr_a)
//   o_data       frame word {top RGB444, bottom RGB444} (to data_in_a)
//   o_wr_en      frame memory write strobe         (to wr_en)
//   o_busy       packet in progress (state != IDLE)
//   o_done       1-cycle pulse: packet completed with good checksum
//   o_err        1-cycle pulse: packet aborted or checksum bad
//   o_err_code   with o_err: 0 timeout, 1 bad command, 2 bad range, 3 checksum
// Revision    : 1.0 - initial release
// ============================================================================
module frame_loader #(
  parameter int          MEM_WORDS = 2304,
  parameter int          TIMEOUT   = 2500000,
  parameter logic [7:0]  SYNC      = 8'hA5
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic        o_rx_ready,
  output logic [11:0] o_addr,
  output logic [23:0] o_data,
  output logic        o_wr_en,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic [1:0]  o_err_code
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [3:0] c_ST_IDLE = 4'd0;
  localparam logic [3:0] c_ST_CMD  = 4'd1;
  localparam logic [3:0] c_ST_ADH  = 4'd2;
  localparam logic [3:0] c_ST_ADL  = 4'd3;
  localparam logic [3:0] c_ST_LNH  = 4'd4;
  localparam logic [3:0] c_ST_LNL  = 4'd5;
  localparam logic [3:0] c_ST_P0   = 4'd6;
  localparam logic [3:0] c_ST_P1   = 4'd7;
  localparam logic [3:0] c_ST_P2   = 4'd8;
  localparam logic [3:0] c_ST_CSUM = 4'd9;
  localparam logic [3:0] c_ST_FILL = 4'd10;

  localparam logic [7:0] c_CMD_WRITE = 8'h01;
  localparam logic [7:0] c_CMD_FILL  = 8'h02;

  localparam logic [1:0] c_ERR_TIMEOUT = 2'd0;
  localparam logic [1:0] c_ERR_CMD     = 2'd1;
  localparam logic [1:0] c_ERR_RANGE   = 2'd2;
  localparam logic [1:0] c_ERR_CSUM    = 2'd3;

  // Timer sized so TIMEOUT-1 always fits, even for tiny test values.
  localparam int                 c_TW        = $clog2(TIMEOUT + 1);
  localparam logic [c_TW-1:0]    c_TO_MAX    = c_TW'(TIMEOUT - 1);
  localparam logic [c_TW-1:0]    c_TO_ONE    = c_TW'(1);
  localparam logic [12:0]        c_MEM_LIMIT = 13'(MEM_WORDS);

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  logic [3:0]      r_state;
  logic [3:0]      w_state_nxt;

  logic            r_is_fill;   // current packet is a fill command
  logic [11:0]     r_base;      // start word address
  logic [7:0]      r_len_h;     // LEN_H kept whole for the [15:12] check
  logic [11:0]     r_len;       // word count (upper nibble proven zero)
  logic [11:0]     r_cnt;       // words issued so far
  logic [7:0]      r_csum;      // running XOR
  logic [15:0]     r_hold;      // P0/P1 bytes awaiting P2
  logic [23:0]     r_colour;    // last assembled word (fill colour)
  logic [c_TW-1:0] r_timer;     // idle cycles since last accepted byte

  // Registered outputs
  logic [11:0]     r_addr;
  logic [23:0]     r_data;
  logic            r_wr_en;
  logic            r_done;
  logic            r_err;
  logic [1:0]      r_err_code;

  // --------------------------------------------------------------------------
  // Decode
  // --------------------------------------------------------------------------
  logic            w_rx_ready;
  logic            w_acc;
  logic            w_in_pkt;
  logic            w_timeout;
  logic            w_cmd_ok;
  logic [15:0]     w_len_full;
  logic [12:0]     w_end_sum;
  logic            w_range_bad;
  logic            w_last_word;
  logic            w_csum_ok;
  logic            w_fill_done;

  logic            w_wr;
  logic [11:0]     w_wr_addr;
  logic [23:0]     w_wr_data;
  logic            w_done;
  logic            w_err;
  logic [1:0]      w_err_code;

  // Ready drops combinationally with reset so no byte is taken during it.
  assign w_rx_ready  = !i_rst && (r_state != c_ST_FILL);
  assign w_acc       = i_rx_valid && w_rx_ready;
  assign w_in_pkt    = (r_state != c_ST_IDLE) && (r_state != c_ST_FILL);
  // An arriving byte wins over an expiring timer in the same cycle.
  assign w_timeout   = w_in_pkt && !w_acc && (r_timer == c_TO_MAX);
  assign w_cmd_ok    = (i_rx_data == c_CMD_WRITE) || (i_rx_data == c_CMD_FILL);

  // Range check is evaluated while LEN_L is on the bus, in 13 bits so the
  // sum of a 12-bit address and a 12-bit count cannot wrap.
  assign w_len_full  = {r_len_h, i_rx_data};
  assign w_end_sum   = {1'b0, r_base} + {1'b0, w_len_full[11:0]};
  assign w_range_bad = (w_len_full == 16'd0) ||
                       (r_len_h[7:4] != 4'd0) ||
                       (w_end_sum > c_MEM_LIMIT);

  assign w_last_word = ((r_cnt + 12'd1) == r_len);
  assign w_csum_ok   = (i_rx_data == r_csum);
  assign w_fill_done = (r_cnt == r_len);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    if (w_timeout) begin
      w_state_nxt = c_ST_IDLE;
    end else begin
      case (r_state)
        c_ST_IDLE: if (w_acc && (i_rx_data == SYNC)) w_state_nxt = c_ST_CMD;
        c_ST_CMD:  if (w_acc) w_state_nxt = w_cmd_ok ? c_ST_ADH : c_ST_IDLE;
        c_ST_ADH:  if (w_acc) w_state_nxt = c_ST_ADL;
        c_ST_ADL:  if (w_acc) w_state_nxt = c_ST_LNH;
        c_ST_LNH:  if (w_acc) w_state_nxt = c_ST_LNL;
        c_ST_LNL:  if (w_acc) w_state_nxt = w_range_bad ? c_ST_IDLE : c_ST_P0;
        c_ST_P0:   if (w_acc) w_state_nxt = c_ST_P1;
        c_ST_P1:   if (w_acc) w_state_nxt = c_ST_P2;
        c_ST_P2: begin
          if (w_acc) begin
            // A fill carries exactly one word; a write carries LEN words.
            w_state_nxt = (r_is_fill || w_last_word) ? c_ST_CSUM : c_ST_P0;
          end
        end
        c_ST_CSUM: begin
          if (w_acc) begin
            w_state_nxt = (w_csum_ok && r_is_fill) ? c_ST_FILL : c_ST_IDLE;
          end
        end
        c_ST_FILL: if (w_fill_done) w_state_nxt = c_ST_IDLE;
        default:   w_state_nxt = c_ST_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // FSM: output decode (values registered into the output stage below)
  // --------------------------------------------------------------------------
  always_comb begin
    w_wr       = 1'b0;
    w_wr_addr  = r_base + r_cnt;
    w_wr_data  = {r_hold, i_rx_data};
    w_done     = 1'b0;
    w_err      = 1'b0;
    w_err_code = c_ERR_TIMEOUT;
    if (w_timeout) begin
      w_err      = 1'b1;
      w_err_code = c_ERR_TIMEOUT;
    end else begin
      case (r_state)
        c_ST_CMD: begin
          if (w_acc && !w_cmd_ok) begin
            w_err      = 1'b1;
            w_err_code = c_ERR_CMD;
          end
        end
        c_ST_LNL: begin
          if (w_acc && w_range_bad) begin
            w_err      = 1'b1;
            w_err_code = c_ERR_RANGE;
          end
        end
        c_ST_P2: begin
          if (w_acc && !r_is_fill) w_wr = 1'b1;
        end
        c_ST_CSUM: begin
          if (w_acc) begin
            if (!w_csum_ok) begin
              w_err      = 1'b1;
              w_err_code = c_ERR_CSUM;
            end else if (r_is_fill) begin
              // First fill word is issued here so the write burst lines up
              // exactly with the cycles spent in FILL.
              w_wr      = 1'b1;
              w_wr_data = r_colour;
            end else begin
              w_done = 1'b1;
            end
          end
        end
        c_ST_FILL: begin
          if (w_fill_done) begin
            w_done = 1'b1;
          end else begin
            w_wr      = 1'b1;
            w_wr_data = r_colour;
          end
        end
        default: ;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_is_fill <= 1'b0;
      r_base    <= 12'd0;
      r_len_h   <= 8'd0;
      r_len     <= 12'd0;
      r_cnt     <= 12'd0;
      r_csum    <= 8'd0;
      r_hold    <= 16'd0;
      r_colour  <= 24'd0;
      r_timer   <= '0;
    end else begin
      if (!w_in_pkt || w_acc || w_timeout) begin
        r_timer <= '0;
      end else begin
        r_timer <= r_timer + c_TO_ONE;
      end

      case (r_state)
        c_ST_CMD: begin
          if (w_acc) begin
            r_csum    <= i_rx_data;
            r_is_fill <= (i_rx_data == c_CMD_FILL);
          end
        end
        c_ST_ADH: begin
          if (w_acc) begin
            r_base[11:8] <= i_rx_data[3:0];
            r_csum       <= r_csum ^ i_rx_data;
          end
        end
        c_ST_ADL: begin
          if (w_acc) begin
            r_base[7:0] <= i_rx_data;
            r_csum      <= r_csum ^ i_rx_data;
          end
        end
        c_ST_LNH: begin
          if (w_acc) begin
            r_len_h <= i_rx_data;
            r_csum  <= r_csum ^ i_rx_data;
          end
        end
        c_ST_LNL: begin
          if (w_acc) begin
            r_len  <= w_len_full[11:0];
            r_cnt  <= 12'd0;
            r_csum <= r_csum ^ i_rx_data;
          end
        end
        c_ST_P0: begin
          if (w_acc) begin
            r_hold[15:8] <= i_rx_data;
            r_csum       <= r_csum ^ i_rx_data;
          end
        end
        c_ST_P1: begin
          if (w_acc) begin
            r_hold[7:0] <= i_rx_data;
            r_csum      <= r_csum ^ i_rx_data;
          end
        end
        c_ST_P2: begin
          if (w_acc) begin
            r_colour <= {r_hold, i_rx_data};
            r_csum   <= r_csum ^ i_rx_data;
            if (!r_is_fill) r_cnt <= r_cnt + 12'd1;
          end
        end
        c_ST_CSUM: begin
          if (w_acc && w_csum_ok && r_is_fill) r_cnt <= 12'd1;
        end
        c_ST_FILL: begin
          if (!w_fill_done) r_cnt <= r_cnt + 12'd1;
        end
        default: ;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Output stage: address/data hold their last value between writes
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_addr     <= 12'd0;
      r_data     <= 24'd0;
      r_wr_en    <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= 2'd0;
    end else begin
      r_wr_en    <= w_wr;
      r_done     <= w_done;
      r_err      <= w_err;
      r_err_code <= w_err_code;
      if (w_wr) begin
        r_addr <= w_wr_addr;
        r_data <= w_wr_data;
      end
    end
  end

  assign o_rx_ready = w_rx_ready;
  assign o_addr     = r_addr;
  assign o_data     = r_data;
  assign o_wr_en    = r_wr_en;
  assign o_busy     = (r_state != c_ST_IDLE);
  assign o_done     = r_done;
  assign o_err      = r_err;
  assign o_err_code = r_err_code;

endmodule

`default_nettype wire

// File: tb/tb_frame_loader.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module      : tb_frame_loader
// Description : Directed self-checking bench for frame_loader. Expected
//               writes and done/error events are queued as each packet is
//               driven; a negedge monitor pops and compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [11:0] addr;
  logic [23:0] data;
  logic        wr_en;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  err_code;

  always #5 clk = ~clk;

  frame_loader #(
    .MEM_WORDS (2304),
    .TIMEOUT   (8),
    .SYNC      (8'hA5)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_rx_data  (rx_data),
    .i_rx_valid (rx_valid),
    .o_rx_ready (rx_ready),
    .o_addr     (addr),
    .o_data     (data),
    .o_wr_en    (wr_en),
    .o_busy     (busy),
    .o_done     (done),
    .o_err      (err),
    .o_err_code (err_code)
  );

  typedef struct packed {
    logic [11:0] a;
    logic [23:0] d;
  } wr_t;

  wr_t        wq[$];     // expected writes, in order
  int         evq[$];    // expected events: 4 = done, 0..3 = error code
  logic [7:0] pkt[$];    // packet under construction
  int         n_total = 0;
  int         n_pass  = 0;
  int         n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic exp_wr(input logic [11:0] a, input logic [23:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    wq.push_back(e);
  endtask

  function automatic logic [7:0] xsum();
    logic [7:0] s = 8'd0;
    for (int i = 1; i < pkt.size(); i++) s = s ^ pkt[i];
    return s;
  endfunction

  // Called at a negedge; drives one byte and returns at the next negedge,
  // by which time the byte has been accepted.
  task automatic send(input logic [7:0] b);
    int w = 0;
    while (!rx_ready && w < 64) begin
      rx_valid = 1'b0;
      @(negedge clk);
      w++;
    end
    if (w >= 64) chk("rx_ready_wait", {31'd0, rx_ready}, 32'd1);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_range(input int first, input int last);
    for (int i = first; i <= last; i++) send(pkt[i]);
  endtask

  task automatic drain();
    rx_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("wr_queue_empty", wq.size(), 32'd0);
    chk("ev_queue_empty", evq.size(), 32'd0);
    chk("idle_not_busy", {31'd0, busy}, 32'd0);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    wr_t ew;
    int  ee;
    if (wr_en) begin
      chk("wr_expected", {31'd0, (wq.size() != 0)}, 32'd1);
      if (wq.size() != 0) begin
        ew = wq.pop_front();
        chk("wr_addr", {20'd0, addr}, {20'd0, ew.a});
        chk("wr_data", {8'd0, data}, {8'd0, ew.d});
      end
    end
    if (done || err) begin
      chk("done_err_exclusive", {31'd0, done & err}, 32'd0);
      chk("ev_expected", {31'd0, (evq.size() != 0)}, 32'd1);
      if (evq.size() != 0) begin
        ee = evq.pop_front();
        chk("ev_code", done ? 32'd4 : {30'd0, err_code}, ee);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_ready_low", {31'd0, rx_ready}, 32'd0);
    chk("rst_ctrl", {26'd0, wr_en, busy, done, err, err_code}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_ready_high", {31'd0, rx_ready}, 32'd1);
    chk("rst_addr", {20'd0, addr}, 32'd0);
    chk("rst_data", {8'd0, data}, 32'd0);
    @(negedge clk);

    // Two-word write to 0x010
    pkt = {8'hA5, 8'h01, 8'h00, 8'h10, 8'h00, 8'h02,
           8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5};
    pkt.push_back(xsum());
    exp_wr(12'h010, 24'hB0B1B2);
    exp_wr(12'h011, 24'hB3B4B5);
    evq.push_back(4);
    send_range(0, 8);
    chk("t1_wr_after_p2", {31'd0, wr_en}, 32'd1);
    chk("t1_wr_addr0", {20'd0, addr}, 32'h010);
    send_range(9, 12);
    rx_valid = 1'b0;
    chk("t1_done_pulse", {30'd0, done, err}, 32'd2);
    drain();

    // Fill 0x8FC..0x8FF with 0x123456
    pkt = {8'hA5, 8'h02, 8'h08, 8'hFC, 8'h00, 8'h04, 8'h12, 8'h34, 8'h56};
    pkt.push_back(xsum());
    for (int i = 0; i < 4; i++) exp_wr(12'h8FC + 12'(i), 24'h123456);
    evq.push_back(4);
    send_range(0, 9);
    rx_valid = 1'b0;
    n = 0;
    while (!rx_ready && n < 32) begin
      n++;
      @(negedge clk);
    end
    chk("t2_ready_low_cycles", n, 32'd4);
    chk("t2_done_after_last", {30'd0, done, busy}, 32'd2);
    drain();

    // Range failure: 0x8FF + 2 > 2304
    pkt = {8'hA5, 8'h01, 8'h08, 8'hFF, 8'h00, 8'h02};
    evq.push_back(2);
    send_range(0, 5);
    rx_valid = 1'b0;
    chk("t3_range_err", {29'd0, err, err_code}, 32'd6);
    chk("t3_no_write", {31'd0, wr_en}, 32'd0);
    drain();

    // Range failure: LEN = 0
    pkt = {8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
    evq.push_back(2);
    send_range(0, 5);
    rx_valid = 1'b0;
    chk("t3_len0_err", {29'd0, err, err_code}, 32'd6);
    drain();

    // Checksum mismatch on a 1-word write: word still written
    pkt = {8'hA5, 8'h01, 8'h00, 8'h20, 8'h00, 8'h01, 8'h11, 8'h22, 8'h33};
    pkt.push_back(xsum() ^ 8'hFF);
    exp_wr(12'h020, 24'h112233);
    evq.push_back(3);
    send_range(0, 9);
    rx_valid = 1'b0;
    chk("t4_csum_err", {29'd0, err, err_code}, 32'd7);
    chk("t4_no_done", {31'd0, done}, 32'd0);
    drain();

    // Checksum mismatch on a fill: no writes at all
    pkt = {8'hA5, 8'h02, 8'h00, 8'h30, 8'h00, 8'h03, 8'h44, 8'h55, 8'h66};
    pkt.push_back(xsum() ^ 8'h01);
    evq.push_back(3);
    send_range(0, 9);
    rx_valid = 1'b0;
    chk("t4_fill_csum_err", {29'd0, err, err_code}, 32'd7);
    drain();

    // Bad command
    pkt = {8'hA5, 8'h07};
    evq.push_back(1);
    send_range(0, 1);
    rx_valid = 1'b0;
    chk("t5_bad_cmd", {29'd0, err, err_code}, 32'd5);
    drain();

    // Timeout: 9-cycle gap after ADDR_L with TIMEOUT = 8
    pkt = {8'hA5, 8'h01, 8'h00, 8'h40};
    evq.push_back(0);
    send_range(0, 3);
    rx_valid = 1'b0;
    repeat (7) @(negedge clk);
    chk("t6_no_early_timeout", {30'd0, err, busy}, 32'd1);
    @(negedge clk);
    chk("t6_timeout_err", {28'd0, err, err_code, busy}, 32'd8);
    drain();

    // Normal packet after the timeout
    pkt = {8'hA5, 8'h01, 8'h01, 8'h23, 8'h00, 8'h01, 8'h9A, 8'hBC, 8'hDE};
    pkt.push_back(xsum());
    exp_wr(12'h123, 24'h9ABCDE);
    evq.push_back(4);
    send_range(0, 9);
    rx_valid = 1'b0;
    chk("t6_recover_done", {31'd0, done}, 32'd1);
    drain();

    // Reset two writes into a LEN=10 fill
    pkt = {8'hA5, 8'h02, 8'h01, 8'h00, 8'h00, 8'h0A, 8'hAB, 8'hCD, 8'hEF};
    pkt.push_back(xsum());
    exp_wr(12'h100, 24'hABCDEF);
    exp_wr(12'h101, 24'hABCDEF);
    send_range(0, 9);
    rx_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t7_ready_low_in_rst", {31'd0, rx_ready}, 32'd0);
    @(negedge clk);
    chk("t7_wr_stopped", {31'd0, wr_en}, 32'd0);
    chk("t7_rst_ctrl", {27'd0, busy, done, err, err_code}, 32'd0);
    chk("t7_rst_addr", {20'd0, addr}, 32'd0);
    chk("t7_rst_data", {8'd0, data}, 32'd0);
    rst = 1'b0;
    #1;
    chk("t7_ready_after_rst", {31'd0, rx_ready}, 32'd1);
    @(negedge clk);

    // Next packet after reset, at the last legal address (0x8FF + 1 = 2304)
    pkt = {8'hA5, 8'h01, 8'h08, 8'hFF, 8'h00, 8'h01, 8'h0A, 8'h0B, 8'h0C};
    pkt.push_back(xsum());
    exp_wr(12'h8FF, 24'h0A0B0C);
    evq.push_back(4);
    send_range(0, 9);
    rx_valid = 1'b0;
    chk("t7_post_rst_done", {31'd0, done}, 32'd1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
